// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funcs,
// ALU operations, FSM states and the registered control word.
package cu_pkg;

    localparam int ALU_OP_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADDU = 5'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 5'd2;
    localparam logic [ALU_OP_W-1:0] ALU_SUBU = 5'd3;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 5'd4;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 5'd5;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 5'd6;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 5'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 5'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 5'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 5'd10;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 5'd11;
    localparam logic [ALU_OP_W-1:0] ALU_SLLV = 5'd12;
    localparam logic [ALU_OP_W-1:0] ALU_SRLV = 5'd13;
    localparam logic [ALU_OP_W-1:0] ALU_MULT = 5'd14;
    localparam logic [ALU_OP_W-1:0] ALU_DIV  = 5'd15;
    localparam logic [ALU_OP_W-1:0] ALU_BEQ  = 5'd16;
    localparam logic [ALU_OP_W-1:0] ALU_BNE  = 5'd17;
    localparam logic [ALU_OP_W-1:0] ALU_BLEZ = 5'd18;
    localparam logic [ALU_OP_W-1:0] ALU_BGTZ = 5'd19;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MULDIV = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R  = 4'd0,
        CLS_ALU_I  = 4'd1,
        CLS_MULDIV = 4'd2,
        CLS_BRANCH = 4'd3,
        CLS_J      = 4'd4,
        CLS_JR     = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_LW     = 4'd7,
        CLS_SW     = 4'd8
    } cls_t;

    typedef struct packed {
        cls_t                cls;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                reg_dest;
    } cw_t;

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decode: (opcode, func) -> control word, with an
// illegal flag for encodings the datapath does not implement.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_func,
    output cw_t        o_cw,
    output logic       o_illegal
);

    always_comb begin
        o_cw      = '0;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_cw.cls      = CLS_ALU_R;
                o_cw.reg_dest = 1'b1;
                case (i_func)
                    F_ADD:  o_cw.alu_op = ALU_ADD;
                    F_ADDU: o_cw.alu_op = ALU_ADDU;
                    F_SUB:  o_cw.alu_op = ALU_SUB;
                    F_SUBU: o_cw.alu_op = ALU_SUBU;
                    F_AND:  o_cw.alu_op = ALU_AND;
                    F_OR:   o_cw.alu_op = ALU_OR;
                    F_XOR:  o_cw.alu_op = ALU_XOR;
                    F_NOR:  o_cw.alu_op = ALU_NOR;
                    F_SLT:  o_cw.alu_op = ALU_SLT;
                    F_SLL:  o_cw.alu_op = ALU_SLL;
                    F_SRL:  o_cw.alu_op = ALU_SRL;
                    F_SRA:  o_cw.alu_op = ALU_SRA;
                    F_SLLV: o_cw.alu_op = ALU_SLLV;
                    F_SRLV: o_cw.alu_op = ALU_SRLV;
                    F_MULT: begin
                        o_cw.cls    = CLS_MULDIV;
                        o_cw.alu_op = ALU_MULT;
                    end
                    F_DIV: begin
                        o_cw.cls    = CLS_MULDIV;
                        o_cw.alu_op = ALU_DIV;
                    end
                    F_JR: begin
                        o_cw.cls      = CLS_JR;
                        o_cw.reg_dest = 1'b0;
                    end
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin o_cw.cls = CLS_ALU_I; o_cw.alu_src = 1'b1; o_cw.alu_op = ALU_ADD;  end
            OP_ADDIU: begin o_cw.cls = CLS_ALU_I; o_cw.alu_src = 1'b1; o_cw.alu_op = ALU_ADDU; end
            OP_ANDI:  begin o_cw.cls = CLS_ALU_I; o_cw.alu_src = 1'b1; o_cw.alu_op = ALU_AND;  end
            OP_ORI:   begin o_cw.cls = CLS_ALU_I; o_cw.alu_src = 1'b1; o_cw.alu_op = ALU_OR;   end
            OP_XORI:  begin o_cw.cls = CLS_ALU_I; o_cw.alu_src = 1'b1; o_cw.alu_op = ALU_XOR;  end
            OP_BEQ:   begin o_cw.cls = CLS_BRANCH; o_cw.alu_op = ALU_BEQ;  end
            OP_BNE:   begin o_cw.cls = CLS_BRANCH; o_cw.alu_op = ALU_BNE;  end
            OP_BLEZ:  begin o_cw.cls = CLS_BRANCH; o_cw.alu_op = ALU_BLEZ; end
            OP_BGTZ:  begin o_cw.cls = CLS_BRANCH; o_cw.alu_op = ALU_BGTZ; end
            OP_J:     o_cw.cls = CLS_J;
            OP_JAL:   o_cw.cls = CLS_JAL;
            OP_LW:    begin o_cw.cls = CLS_LW; o_cw.alu_src = 1'b1; o_cw.alu_op = ALU_ADD; end
            OP_SW:    begin o_cw.cls = CLS_SW; o_cw.alu_src = 1'b1; o_cw.alu_op = ALU_ADD; end
            default:  o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences each instruction through
// FETCH/DECODE/EXEC/(MULDIV|MEM)/WB with a memory ready handshake.
//   state  | meaning
//   FETCH  | read instruction at PC, load IR and bump PC on mem_ready
//   DECODE | latch control word, trap illegal encodings
//   EXEC   | ALU operation, branch/jump resolution
//   MULDIV | multi-cycle MULT/DIV, down-counter to terminal count
//   MEM    | data access at ALU address, wait for mem_ready
//   WB     | single register-file write
//   HALT   | sticky stop after an illegal encoding, reset exits
module mc_control_unit
    import cu_pkg::*;
#(
    parameter int ALUOP_W       = 5,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               mem_ready,
    output logic               RegDest,
    output logic               Jump,
    output logic               JumpReg,
    output logic               Branch,
    output logic               MemToReg,
    output logic               Link,
    output logic               MemWrite,
    output logic               ALUsrc,
    output logic               MemRead,
    output logic               RegWrite,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               IorD,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [2:0]         state,
    output logic               Halted
);

    localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    cw_t                 r_cw;
    logic [CNT_W-1:0]    r_cnt;
    cw_t                 w_cw;
    logic                w_illegal;
    logic [ALU_OP_W-1:0] w_alu_op;

    cu_decoder u_dec (
        .i_opcode  (opcode),
        .i_func    (func),
        .o_cw      (w_cw),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state <= ST_FETCH;
            r_cw    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE)
                r_cw <= w_cw;
            if (r_state == ST_EXEC && r_cw.cls == CLS_MULDIV)
                r_cnt <= CNT_LOAD;
            else if (r_state == ST_MULDIV && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:  if (mem_ready) w_next = ST_DECODE;
            ST_DECODE: w_next = w_illegal ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                case (r_cw.cls)
                    CLS_ALU_R, CLS_ALU_I, CLS_JAL: w_next = ST_WB;
                    CLS_MULDIV: w_next = (MULDIV_CYCLES == 1) ? ST_WB : ST_MULDIV;
                    CLS_LW, CLS_SW:                w_next = ST_MEM;
                    default:                       w_next = ST_FETCH;
                endcase
            end
            // Leaving when the count is about to reach zero gives exactly
            // MULDIV_CYCLES-1 cycles here.
            ST_MULDIV: if (r_cnt <= CNT_W'(1)) w_next = ST_WB;
            ST_MEM: begin
                if (mem_ready)
                    w_next = (r_cw.cls == CLS_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB:     w_next = ST_FETCH;
            ST_HALT:   w_next = ST_HALT;
            default:   w_next = ST_FETCH;
        endcase
    end

    always_comb begin
        RegDest  = 1'b0;
        Jump     = 1'b0;
        JumpReg  = 1'b0;
        Branch   = 1'b0;
        MemToReg = 1'b0;
        Link     = 1'b0;
        MemWrite = 1'b0;
        ALUsrc   = 1'b0;
        MemRead  = 1'b0;
        RegWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        Halted   = 1'b0;
        w_alu_op = '0;
        case (r_state)
            ST_FETCH: begin
                MemRead = 1'b1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            ST_EXEC: begin
                w_alu_op = r_cw.alu_op;
                ALUsrc   = r_cw.alu_src;
                RegDest  = r_cw.reg_dest;
                Branch   = (r_cw.cls == CLS_BRANCH);
                Jump     = (r_cw.cls == CLS_J) || (r_cw.cls == CLS_JR) || (r_cw.cls == CLS_JAL);
                JumpReg  = (r_cw.cls == CLS_JR);
            end
            ST_MULDIV: w_alu_op = r_cw.alu_op;
            ST_MEM: begin
                IorD     = 1'b1;
                MemRead  = (r_cw.cls == CLS_LW);
                MemWrite = (r_cw.cls == CLS_SW);
            end
            ST_WB: begin
                RegWrite = 1'b1;
                RegDest  = r_cw.reg_dest;
                MemToReg = (r_cw.cls == CLS_LW);
                Link     = (r_cw.cls == CLS_JAL);
            end
            ST_HALT: Halted = 1'b1;
            default: ;
        endcase
        // Reset masks everything immediately so an aborted MEM/MULDIV
        // cannot leak a strobe while rst_b is low.
        if (!rst_b) begin
            RegDest  = 1'b0;
            Jump     = 1'b0;
            JumpReg  = 1'b0;
            Branch   = 1'b0;
            MemToReg = 1'b0;
            Link     = 1'b0;
            MemWrite = 1'b0;
            ALUsrc   = 1'b0;
            MemRead  = 1'b0;
            RegWrite = 1'b0;
            IorD     = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            Halted   = 1'b0;
            w_alu_op = '0;
        end
    end

    assign ALUOp = ALUOP_W'(w_alu_op);
    assign state = rst_b ? r_state : 3'b000;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed cycle-by-cycle bench for mc_control_unit; every cycle's full
// output vector is compared against a hand-written expectation.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       rst_b;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       mem_ready;
    logic       RegDest, Jump, JumpReg, Branch, MemToReg, Link, MemWrite;
    logic       ALUsrc, MemRead, RegWrite, IorD, IRWrite, PCWrite, Halted;
    logic [4:0] ALUOp;
    logic [2:0] state;

    int n_vec = 0;
    int n_err = 0;

    // {state, 14 flags, ALUOp}
    logic [21:0] obs;
    assign obs = {state, Halted, RegDest, Jump, JumpReg, Branch, MemToReg, Link,
                  MemWrite, ALUsrc, MemRead, RegWrite, IorD, IRWrite, PCWrite, ALUOp};

    localparam logic [13:0] H   = 14'h2000, RD  = 14'h1000, J   = 14'h0800, JR  = 14'h0400;
    localparam logic [13:0] BR  = 14'h0200, M2R = 14'h0100, LK  = 14'h0080, MW  = 14'h0040;
    localparam logic [13:0] AS  = 14'h0020, MR  = 14'h0010, RW  = 14'h0008, IOD = 14'h0004;
    localparam logic [13:0] IRW = 14'h0002, PCW = 14'h0001, NONE = 14'h0000;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_MD = 3'd3;
    localparam logic [2:0] S_M = 3'd4, S_W = 3'd5, S_H = 3'd6;

    localparam logic [4:0] A_ADD = 5'd0, A_OR = 5'd5, A_MULT = 5'd14, A_BEQ = 5'd16;

    mc_control_unit #(.ALUOP_W(5), .MULDIV_CYCLES(4)) dut (
        .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func), .mem_ready(mem_ready),
        .RegDest(RegDest), .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch),
        .MemToReg(MemToReg), .Link(Link), .MemWrite(MemWrite), .ALUsrc(ALUsrc),
        .MemRead(MemRead), .RegWrite(RegWrite), .ALUOp(ALUOp), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .state(state), .Halted(Halted)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] ev(input logic [2:0] st, input logic [13:0] fl,
                                       input logic [4:0] op);
        return {st, fl, op};
    endfunction

    task automatic check(input logic [21:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive mem_ready for the current cycle, check, then advance one clock.
    task automatic cyc(input logic mr, input logic [21:0] exp, input string tag);
        mem_ready = mr;
        #1;
        check(exp, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b = 1'b0; mem_ready = 1'b0; opcode = 6'd0; func = 6'd0;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b1;
        #1 check(ev(S_F, NONE, 5'd0), "reset_forced_zero");
        rst_b = 1'b1;

        // ADD: 4 cycles
        opcode = 6'b000000; func = 6'b100000;
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "add_fetch");
        cyc(1, ev(S_D, NONE, 0),           "add_decode");
        cyc(1, ev(S_E, RD, A_ADD),         "add_exec");
        cyc(1, ev(S_W, RD | RW, A_ADD),    "add_wb");

        // LW with one FETCH stall and two MEM stalls
        opcode = 6'b100011;
        cyc(0, ev(S_F, MR, 0),             "lw_fetch_stall");
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "lw_fetch");
        cyc(0, ev(S_D, NONE, 0),           "lw_decode");
        cyc(0, ev(S_E, AS, A_ADD),         "lw_exec");
        cyc(0, ev(S_M, IOD | MR, 0),       "lw_mem_stall1");
        cyc(0, ev(S_M, IOD | MR, 0),       "lw_mem_stall2");
        cyc(1, ev(S_M, IOD | MR, 0),       "lw_mem_done");
        cyc(1, ev(S_W, M2R | RW, 0),       "lw_wb");

        // MULT: 3 MULDIV cycles
        opcode = 6'b000000; func = 6'b011000;
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "mult_fetch");
        cyc(1, ev(S_D, NONE, 0),           "mult_decode");
        cyc(1, ev(S_E, RD, A_MULT),        "mult_exec");
        cyc(1, ev(S_MD, NONE, A_MULT),     "mult_md1");
        cyc(0, ev(S_MD, NONE, A_MULT),     "mult_md2");
        cyc(1, ev(S_MD, NONE, A_MULT),     "mult_md3");
        cyc(1, ev(S_W, RD | RW, 0),        "mult_wb");

        // BEQ then JAL
        opcode = 6'b000100;
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "beq_fetch");
        cyc(1, ev(S_D, NONE, 0),           "beq_decode");
        cyc(1, ev(S_E, BR, A_BEQ),         "beq_exec");
        opcode = 6'b000011;
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "jal_fetch");
        cyc(1, ev(S_D, NONE, 0),           "jal_decode");
        cyc(1, ev(S_E, J, 0),              "jal_exec");
        cyc(1, ev(S_W, LK | RW, 0),        "jal_wb");

        // JR and ORI
        opcode = 6'b000000; func = 6'b001000;
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "jr_fetch");
        cyc(1, ev(S_D, NONE, 0),           "jr_decode");
        cyc(1, ev(S_E, J | JR, 0),         "jr_exec");
        opcode = 6'b001101;
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "ori_fetch");
        cyc(1, ev(S_D, NONE, 0),           "ori_decode");
        cyc(1, ev(S_E, AS, A_OR),          "ori_exec");
        cyc(1, ev(S_W, RW, 0),             "ori_wb");

        // Illegal opcode -> sticky HALT, then reset
        opcode = 6'b111111;
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "ill_fetch");
        cyc(1, ev(S_D, NONE, 0),           "ill_decode");
        for (int i = 0; i < 10; i++)
            cyc(i[0], ev(S_H, H, 0), "ill_halt");
        rst_b = 1'b0;
        #1 check(ev(S_F, NONE, 0), "halt_rst_forced");
        @(posedge clk);
        #1 rst_b = 1'b1;
        opcode = 6'b000000; func = 6'b111111;
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "post_halt_fetch");
        cyc(1, ev(S_D, NONE, 0),           "illfunc_decode");
        cyc(1, ev(S_H, H, 0),              "illfunc_halt");
        rst_b = 1'b0;
        @(posedge clk);
        #1 rst_b = 1'b1;

        // SW: reset during MEM stall aborts the write
        opcode = 6'b101011;
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "sw_fetch");
        cyc(1, ev(S_D, NONE, 0),           "sw_decode");
        cyc(1, ev(S_E, AS, A_ADD),         "sw_exec");
        cyc(0, ev(S_M, IOD | MW, 0),       "sw_mem_stall");
        rst_b = 1'b0;
        #1 check(ev(S_F, NONE, 0), "sw_rst_drop");
        @(posedge clk);
        #1 rst_b = 1'b1;
        cyc(0, ev(S_F, MR, 0),             "sw_rst_fetch");
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "sw2_fetch");
        cyc(1, ev(S_D, NONE, 0),           "sw2_decode");
        cyc(1, ev(S_E, AS, A_ADD),         "sw2_exec");
        cyc(1, ev(S_M, IOD | MW, 0),       "sw2_mem");
        cyc(1, ev(S_F, MR | IRW | PCW, 0), "sw2_next_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle MIPS control unit: a parametrised successor to the single-cycle decoder, sequencing each instruction through FETCH/DECODE/EXEC/MEM/WB states. Adds a memory ready handshake, multi-cycle MULT/DIV stalls and a sticky halt on illegal encodings. Sits between the instruction register (opcode/func) and the shared datapath (ALU, register file, PC, unified memory port).

## Interface

**Parameters**
- `ALUOP_W`, default 5: width of the ALU operation code.
- `MULDIV_CYCLES`, default 4: EXEC cycles consumed by MULT/DIV. Legal range is at least 1.

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `rst_b`, input, 1: reset, synchronous, active-low.
- `opcode`, input, 6: IR[31:26]. Valid from DECODE onward.
- `func`, input, 6: IR[5:0].
- `mem_ready`, input, 1: memory completed the current MemRead/MemWrite this cycle.
- `RegDest`, `Jump`, `JumpReg`, `Branch`, `MemToReg`, `Link`, `MemWrite`, `ALUsrc`, `MemRead`, `RegWrite`: output, 1 each. Datapath controls.
- `ALUOp`, output, `ALUOP_W`: ALU operation.
- `IorD`, output, 1: memory address select (0 = PC, 1 = ALU result).
- `IRWrite`, output, 1: load the instruction register.
- `PCWrite`, output, 1: PC <= PC+4.
- `state`, output, 3: current FSM state, for debug.
- `Halted`, output, 1: sticky halt.

## Operation

- **States:** FETCH, DECODE, EXEC, MULDIV, MEM, WB, HALT.
- **FETCH:** asserts MemRead with IorD=0.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready=1, asserts IRWrite and PCWrite in the same cycle, then goes to DECODE.
- **DECODE:** registers the control word from opcode/func into the decode register.
  - Undefined R-type func or undefined opcode → HALT.
  - Otherwise → EXEC.
- **EXEC:** drives ALUOp, ALUsrc and RegDest from the decode register.
  - R-type ALU ops (ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLL, SRL, SRA, SLLV, SRLV) → WB.
  - ADDI, ADDIU, ANDI, ORI, XORI: ALUsrc=1 → WB.
  - MULT/DIV → MULDIV, loading the counter with MULDIV_CYCLES-1. If MULDIV_CYCLES=1 → WB directly.
  - BEQ/BNE/BLEZ/BGTZ: Branch=1 for one cycle with the matching comparison ALUOp → FETCH.
  - J: Jump=1 → FETCH.
  - JR: Jump=JumpReg=1 → FETCH.
  - JAL: Jump=1 → WB.
  - LW/SW: ALUsrc=1, ALUOp=ADD → MEM.
- **MULDIV:** ALUOp held.
  - Counter decrements each cycle.
  - At 0 → WB.
- **MEM:** IorD=1. LW asserts MemRead; SW asserts MemWrite.
  - Holds while mem_ready=0.
  - On mem_ready=1: LW → WB, SW → FETCH.
- **WB:** RegWrite=1 for exactly one cycle, then → FETCH.
  - LW: MemToReg=1.
  - JAL: Link=1, writing PC+4 to $31.
  - R-type: RegDest=1.
- **HALT:** Halted=1. All other outputs are 0. No exit except reset.
- Every output not named for a state is 0 in that state.

## Timing

- **Reset:** rst_b=0 at a clock edge forces state to FETCH, clears the counter, clears Halted and clears the decode register.
  - While rst_b=0, all outputs are forced to 0 combinationally.
  - Reset mid-MEM or mid-MULDIV aborts with no write strobe in the following cycle.
- **Latency** (mem_ready held at 1): counted from the first FETCH cycle to the first FETCH of the next instruction.
  - Branch, J, JR: 3 cycles.
  - R-type, I-type ALU, JAL: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - MULT/DIV: 4 + MULDIV_CYCLES - 1 cycles.
- Each cycle of mem_ready=0 in FETCH or MEM adds 1 cycle.
- mem_ready is ignored outside FETCH and MEM.
- Outputs are Moore-style: a function of state and the decode register only. The one exception is FETCH's IRWrite/PCWrite, gated by mem_ready.
- Write strobes (RegWrite, MemWrite, PCWrite, IRWrite) are each high for exactly one accepted cycle per instruction.

## Structure

- **Package `cu_pkg`:**
  - opcode/func constants.
  - ALU op constants, `ALUOP_W` wide.
  - State enum.
  - Packed control-word struct.
- **Sub-module `cu_decoder`:** purely combinational (opcode, func) → control word plus an `illegal` flag.
- **`mc_control_unit`** owns the FSM, the decode register and the MULDIV counter.

## Test plan

- **ADD, mem_ready=1:** states FETCH, DECODE, EXEC, WB. RegWrite=1 only in WB with RegDest=1 and ALUOp=ALU_ADD. Next FETCH at cycle 5.
- **LW with mem_ready=0 for 2 MEM cycles:** MemRead and IorD=1 held for 3 MEM cycles. Then WB with MemToReg=1. Total 7 cycles.
- **MULT with MULDIV_CYCLES=4:** exactly 3 MULDIV cycles with ALUOp=ALU_MULT. Then one RegWrite pulse.
- **BEQ, then JAL:** BEQ gives Branch=1 for 1 EXEC cycle, 3 cycles total. JAL gives Jump in EXEC and Link=RegWrite=1 in WB.
- **Opcode 6'b111111:** HALT after DECODE. Halted stays 1 for 10 cycles with all strobes 0. rst_b=0 for one edge returns to FETCH with Halted=0.
- **rst_b=0 asserted during SW's MEM stall:** MemWrite drops immediately. The next state is FETCH and no write occurs.
